// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcode, state and mux-select constants for the multicycle RV32I control unit
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b111;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp/funct3/funct7b5 to the 3-bit ALUControl code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALUCTL_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type with funct7b5 set is sub; addi never subtracts.
          3'b000:  o_alu_control = ({i_op5, i_funct7b5} == 2'b11) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  o_alu_control = ALUCTL_SLT;
          3'b110:  o_alu_control = ALUCTL_OR;
          3'b111:  o_alu_control = ALUCTL_AND;
          default: o_alu_control = ALUCTL_ADD;
        endcase
      end
      default: o_alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I Moore control FSM; ILLEGAL_TRAP_EN adds a sticky illegal-opcode trap
module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  logic       w_known_op;
  logic       w_pc_update, w_branch, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic [1:0] w_result_src, w_src_a, w_src_b, w_alu_op;

  assign w_known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (!w_known_op) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end else begin
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECUTER;
            OP_I:         w_next = S_EXECUTEI;
            OP_BEQ:       w_next = S_BEQ;
            OP_JAL:       w_next = S_JAL;
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_pc_update  = 1'b1;
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        w_src_a  = SRCA_RS1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      S_JAL: begin
        w_src_a     = SRCA_OLDPC;
        w_src_b     = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Write enables are gated by reset so an aborted instruction leaves no side effects.
  assign PCWrite   = ~reset & (w_pc_update | (w_branch & Zero));
  assign IRWrite   = ~reset & w_ir_write;
  assign MemWrite  = ~reset & w_mem_write;
  assign RegWrite  = ~reset & w_reg_write;
  assign AdrSrc    = w_adr_src;
  assign ResultSrc = w_result_src;
  assign ALUSrcA   = w_src_a;
  assign ALUSrcB   = w_src_b;

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (reset)                                   r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_known_op) r_illegal <= 1'b1;
  end
  assign Illegal = r_illegal;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - vector table, illegal-opcode sequence and random instruction stream against a per-instruction model
module tb_multicycle_control;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [15:0] ALL = 16'hFFFF;
  localparam logic [15:0] EN  = 16'hB001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal)
  );

  wire [15:0] act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ImmSrc, ALUControl, RegWrite};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [15:0] exp;
    logic [15:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] pk(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic [2:0] alu, input logic rw);
    return {pcw, adr, mw, irw, res, a, b, imm, alu, rw};
  endfunction

  function automatic logic [15:0] fe(input logic [1:0] imm);
    return pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction

  function automatic logic [15:0] de(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endfunction

  task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic [15:0] e, input logic [15:0] m);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e; v.mask = m;
    tbl.push_back(v);
  endtask

  task automatic apply_check(input string name, input logic rst, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [15:0] e, input logic [15:0] m,
                             input logic ill);
    @(negedge clk);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    #1;
    n_vec++;
    if ((((act ^ e) & m) !== 16'h0) || (Illegal !== ill)) begin
      n_err++;
      $display("FAIL %s: outputs=%h Illegal=%b, expected outputs=%h Illegal=%b (mask %h)",
               name, act & m, Illegal, e & m, ill, m);
    end
  endtask

  // Reference: what each instruction does cycle by cycle, from the instruction's meaning.
  function automatic int ilen(input int cls);
    case (cls)
      0: return 5;
      4: return 3;
      6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] cls_op(input int cls);
    case (cls)
      0: return LW; 1: return SW; 2: return RT; 3: return IT; 4: return BQ; 5: return JL;
      default: return BAD;
    endcase
  endfunction

  function automatic logic [2:0] func_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] model(input int cls, input int k, input logic [2:0] f3,
                                        input logic f7, input logic z);
    logic [1:0] imm;
    imm = (cls == 1) ? 2'b01 : (cls == 4) ? 2'b10 : (cls == 5) ? 2'b11 : 2'b00;
    if (k == 0) return fe(imm);
    if (k == 1) return de(imm);
    case (cls)
      0: case (k)
           2: return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0);
           3: return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
           default: return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1);
         endcase
      1: if (k == 2) return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0);
         else        return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
      2: if (k == 2) return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, func_alu(1, f3, f7), 0);
         else        return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
      3: if (k == 2) return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, func_alu(0, f3, f7), 0);
         else        return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
      4: return pk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 0);
      5: if (k == 2) return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0);
         else        return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
      default: return 16'h0;
    endcase
  endfunction

  initial begin
    int ncls;
    logic ill_trap;

    add(1, LW, 0, 0, 0, 16'h0, EN);
    add(1, LW, 0, 0, 0, 16'h0, EN);
    // lw
    add(0, LW, 0, 0, 0, fe(0), ALL);
    add(0, LW, 0, 0, 0, de(0), ALL);
    add(0, LW, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), ALL);
    add(0, LW, 0, 0, 0, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), ALL);
    add(0, LW, 0, 0, 0, pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1), ALL);
    // sub, add, slt, and
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f3v;
      logic       f7v;
      logic [2:0] alu;
      f3v = (i == 2) ? 3'd2 : (i == 3) ? 3'd7 : 3'd0;
      f7v = (i == 0);
      alu = (i == 0) ? 3'b001 : (i == 1) ? 3'b000 : (i == 2) ? 3'b101 : 3'b111;
      add(0, RT, f3v, f7v, 0, fe(0), ALL);
      add(0, RT, f3v, f7v, 0, de(0), ALL);
      add(0, RT, f3v, f7v, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0), ALL);
      add(0, RT, f3v, f7v, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), ALL);
    end
    // addi with funct7b5=1 stays add; ori
    add(0, IT, 0, 1, 0, fe(0), ALL);
    add(0, IT, 0, 1, 0, de(0), ALL);
    add(0, IT, 0, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), ALL);
    add(0, IT, 0, 1, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), ALL);
    add(0, IT, 6, 0, 0, fe(0), ALL);
    add(0, IT, 6, 0, 0, de(0), ALL);
    add(0, IT, 6, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0), ALL);
    add(0, IT, 6, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), ALL);
    // beq taken (Zero held high, must not leak into DECODE) and not taken
    add(0, BQ, 0, 0, 1, fe(2), ALL);
    add(0, BQ, 0, 0, 1, de(2), ALL);
    add(0, BQ, 0, 0, 1, pk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0), ALL);
    add(0, BQ, 0, 0, 0, fe(2), ALL);
    add(0, BQ, 0, 0, 0, de(2), ALL);
    add(0, BQ, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0), ALL);
    // jal
    add(0, JL, 0, 0, 0, fe(3), ALL);
    add(0, JL, 0, 0, 0, de(3), ALL);
    add(0, JL, 0, 0, 0, pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0), ALL);
    add(0, JL, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1), ALL);
    // sw
    add(0, SW, 0, 0, 0, fe(1), ALL);
    add(0, SW, 0, 0, 0, de(1), ALL);
    add(0, SW, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0), ALL);
    add(0, SW, 0, 0, 0, pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0), ALL);
    // lw aborted by reset in its write-back cycle, then a full lw
    add(0, LW, 0, 0, 0, fe(0), ALL);
    add(0, LW, 0, 0, 0, de(0), ALL);
    add(0, LW, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), ALL);
    add(0, LW, 0, 0, 0, pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), ALL);
    add(1, LW, 0, 0, 0, 16'h0, EN);
    for (int k = 0; k < 5; k++) add(0, LW, 0, 0, 0, model(0, k, 0, 0, 0), ALL);

    for (int i = 0; i < tbl.size(); i++)
      apply_check($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z,
                  tbl[i].exp, tbl[i].mask, 1'b0);

    apply_check("bad_fetch", 0, BAD, 0, 0, 0, fe(0), ALL, 0);
    apply_check("bad_decode", 0, BAD, 0, 0, 0, de(0), ALL, 0);
`ifdef ILLEGAL_TRAP_EN
    apply_check("trap_enter", 0, BAD, 0, 0, 0, 16'h0, ALL, 1);
    for (int i = 0; i < 3; i++) apply_check("trap_hold", 0, LW, 0, 0, 1, 16'h0, ALL, 1);
    ill_trap = 1'b1;
`else
    apply_check("bad_refetch", 0, LW, 0, 0, 0, fe(0), ALL, 0);
    ill_trap = 1'b0;
`endif
    apply_check("reset_again", 1, LW, 0, 0, 0, 16'h0, EN, ill_trap);
    apply_check("fetch_after_reset", 0, LW, 0, 0, 0, fe(0), ALL, 0);
    apply_check("reset_again2", 1, LW, 0, 0, 0, 16'h0, EN, 0);

`ifdef ILLEGAL_TRAP_EN
    ncls = 6;
`else
    ncls = 7;
`endif
    for (int n = 0; n < 400; n++) begin
      int         cls;
      logic [2:0] f3r;
      logic       f7r;
      cls = $urandom_range(0, ncls - 1);
      f3r = 3'($urandom);
      f7r = 1'($urandom);
      for (int k = 0; k < ilen(cls); k++) begin
        logic zr;
        zr = 1'($urandom);
        apply_check($sformatf("rand%0d_cls%0d_k%0d", n, cls, k), 0, cls_op(cls), f3r, f7r, zr,
                    model(cls, k, f3r, f7r, zr), ALL, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
